// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding, default width
// and the counter-width helper.
package serial_adder_pkg;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Bit counter width: max(1, ceil(log2(w))).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_lab001.sv
// lab001: the existing 1-bit full adder cell reused by the serial adder.
module lab001 (
  input  logic A,
  input  logic B,
  input  logic Ci,
  output logic S,
  output logic Co
);

  assign S  = A ^ B ^ Ci;
  assign Co = (A & B) | (Ci & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: feeds one operand bit per clock (LSB first) into
// the lab001 cell, with the carry held in a flip-flop between steps.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int unsigned         CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_co;
  logic [CNT_W-1:0] r_cnt;

  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_sum_next;

  lab001 u_fa (
    .A  (r_sh_a[0]),
    .B  (r_sh_b[0]),
    .Ci (r_carry),
    .S  (w_s),
    .Co (w_co)
  );

  // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH steps.
  always_comb begin
    w_sum_next            = r_sum >> 1;
    w_sum_next[WIDTH-1]   = w_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sh_a  <= '0;
      r_sh_b  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sh_a  <= a;
            r_sh_b  <= b;
            r_carry <= ci;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_co;
          r_sh_a  <= r_sh_a >> 1;
          r_sh_b  <= r_sh_b >> 1;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_co    <= w_co;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign co   = r_co;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1 against {co,sum} = a + b + ci.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int unsigned W = DEFAULT_WIDTH;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         start, ci, busy, done, co;
  logic [W-1:0] a, b, sum;
  logic         start1, ci1, busy1, done1, co1;
  logic [0:0]   a1, b1, sum1;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done1_cnt = 0;
  logic         last_co = 1'b0;
  logic [W:0]   exp_q[$];
  logic [1:0]   exp1_q[$];

  serial_adder #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .sum(sum), .co(co)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .ci(ci1),
    .busy(busy1), .done(done1), .sum(sum1), .co(co1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c);
    return (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
  endfunction

  // Monitors: pop the oldest expectation whenever a done pulse is presented.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual done=1 required done=0 (sum=%0h)", sum);
      end else begin
        check("sum_co_w8", {co, sum}, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done1 === 1'b1) begin
      done1_cnt++;
      if (exp1_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done_w1 actual done=1 required done=0 (sum=%0h)", sum1);
      end else begin
        check("sum_co_w1", {co1, sum1}, exp1_q.pop_front());
      end
    end
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int n;
    int busy_n;
    logic [W:0] e;
    e = model(x, y, c);
    @(negedge clk);
    start = 1'b1; a = x; b = y; ci = c;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("sum_cleared_on_start", sum, 0);
    check("co_held_on_start", co, last_co);
    n = 1;
    busy_n = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && n < W + 4) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) busy_n++;
    end
    check("done_latency", n, W + 1);
    check("busy_cycles", busy_n, W);
    check("busy_low_in_done", busy, 0);
    last_co = e[W];
    @(negedge clk);
    check("done_single_pulse", done, 0);
  endtask

  initial begin
    int base;
    logic [W:0] e;
    start = 0; a = '0; b = '0; ci = 0;
    start1 = 0; a1 = '0; b1 = '0; ci1 = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_sum", sum, 0);
    check("reset_co", co, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(8'h00, 8'h00, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0);
    run_op(8'h5A, 8'hA5, 1'b1);

    // start and new operands during RUN must be ignored
    base = done_cnt;
    @(negedge clk);
    start = 1'b1; a = 8'h12; b = 8'h34; ci = 1'b0;
    exp_q.push_back(model(8'h12, 8'h34, 1'b0));
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (W + 6) @(negedge clk);
    check("midrun_start_one_done", done_cnt - base, 1);

    // reset in the middle of RUN aborts the operation
    @(negedge clk);
    start = 1'b1; a = 8'h55; b = 8'h22; ci = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_abort", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_sum", sum, 0);
    check("abort_co", co, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    base = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    last_co = 1'b0;
    repeat (W + 4) @(negedge clk);
    check("no_done_after_abort", done_cnt - base, 0);
    run_op(8'h03, 8'h04, 1'b0);

    // back-to-back with start held high; operands toggle between accepts
    base = done_cnt;
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      a = W'($urandom()); b = W'($urandom()); ci = 1'($urandom());
      e = model(a, b, ci);
      exp_q.push_back(e);
      repeat (W + 1) begin
        @(negedge clk);
        a = W'($urandom()); b = W'($urandom()); ci = 1'($urandom());
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    check("b2b_done_count", done_cnt - base, 200);
    check("b2b_queue_drained", exp_q.size(), 0);

    // WIDTH=1: all eight operand combinations back to back
    start1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a1 = k[0]; b1 = k[1]; ci1 = k[2];
      exp1_q.push_back(2'(k[0]) + 2'(k[1]) + 2'(k[2]));
      repeat (2) begin
        @(negedge clk);
        a1 = 1'($urandom()); b1 = 1'($urandom()); ci1 = 1'($urandom());
      end
      @(negedge clk);
    end
    start1 = 1'b0;
    repeat (5) @(negedge clk);
    check("w1_done_count", done1_cnt, 8);
    check("w1_queue_drained", exp1_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
